// File: rtl/fifo_stream_adapter_pkg.sv
// rtl/fifo_stream_adapter_pkg.sv - shared widths, beat type and helpers for the fifo stream adapter
package fifo_stream_adapter_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PKT_CNT_W      = 16;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      last;
  } beat_t;

  // Beat counter needs at least one bit even when every beat is the last.
  function automatic int beat_w(input int pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_adapter_ring_buf.sv
// rtl/fifo_stream_adapter_ring_buf.sv - prefetch ring buffer with occupancy count and head output
module fifo_stream_adapter_ring_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  localparam int PTR_W     = $clog2(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [PTR_W:0]        occ
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [PTR_W:0]        occ_q, occ_d;

  assign head_data = mem_q[head_q];
  assign occ       = occ_q;

  // Clearing snaps head onto tail instead of zeroing both; storage is left as is.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr) begin
      head_d = tail_q;
      occ_d  = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !clr) begin
      mem_q[tail_q] <= push_data;
    end
  end

endmodule

// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - pulls words from a sync fifo and presents a framed valid/ready stream
module fifo_stream_adapter
  import fifo_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH  = 4,
  parameter int PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [PKT_CNT_W-1:0]  pkt_cnt
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int BEAT_W = beat_w(PKT_LEN);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(PKT_LEN - 1);
  localparam logic [PTR_W+1:0]   DEPTH_L   = (PTR_W + 2)'(BUF_DEPTH);

  logic                 pend_q, pend_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [PTR_W:0]       occ;
  logic                 push;
  logic                 xfer;

  // A read is only issued when the word it returns is guaranteed a slot.
  assign fifo_rd_en = !fifo_empty && !flush &&
                      (({1'b0, occ} + (PTR_W + 2)'(pend_q)) < DEPTH_L);

  assign m_valid = (occ != '0);
  assign m_last  = m_valid && (beat_q == LAST_BEAT);
  assign xfer    = m_valid && m_ready && !flush;
  assign push    = pend_q && !flush;
  assign pkt_cnt = pkt_cnt_q;

  fifo_stream_adapter_ring_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (xfer),
    .head_data (m_data),
    .occ       (occ)
  );

  always_comb begin
    pend_d    = fifo_rd_en;
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
    if (flush) begin
      beat_d = '0;
    end else if (xfer) begin
      if (m_last) begin
        beat_d    = '0;
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      beat_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      pend_q    <= pend_d;
      beat_q    <= beat_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb/tb_fifo_stream_adapter.sv - fifo model plus scoreboard bench for fifo_stream_adapter
module tb_fifo_stream_adapter;
  import fifo_stream_adapter_pkg::*;

  localparam int DW         = 8;
  localparam int BUF_DEPTH  = 4;
  localparam int PKT_LEN    = 4;
  localparam int FIFO_DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [15:0]   pkt_cnt;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  always #5 clk = ~clk;

  fifo_stream_adapter #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (BUF_DEPTH),
    .PKT_LEN    (PKT_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .pkt_cnt      (pkt_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb[$];
  int            beat_m = 0;
  logic [15:0]   pkt_m = '0;
  logic          stall_prev = 1'b0;
  beat_t         held;
  int            drop_n;
  logic [DW-1:0] exp_w;

  logic          s_rstn = 1'b0, s_valid = 1'b0, s_ready = 1'b0, s_last = 1'b0;
  logic          s_flush = 1'b0, s_rd_en = 1'b0, s_empty = 1'b1, s_wr_en = 1'b0;
  logic [DW-1:0] s_data = '0, s_wr_data = '0;
  logic [15:0]   s_pkt = '0;

  int          c0;
  int          nbeat;
  logic [15:0] mask;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    s_rstn    = rst_n;
    s_valid   = m_valid;
    s_ready   = m_ready;
    s_data    = m_data;
    s_last    = m_last;
    s_pkt     = pkt_cnt;
    s_flush   = flush;
    s_rd_en   = fifo_rd_en;
    s_empty   = fifo_empty;
    s_wr_en   = wr_en;
    s_wr_data = wr_data;
  end

  // Fifo model and scoreboard monitor: acts on the values sampled mid-cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      sb.delete();
      beat_m       = 0;
      pkt_m        = '0;
      stall_prev   = 1'b0;
      fifo_rd_data <= '0;
      fifo_empty   <= 1'b1;
    end else if (s_rstn) begin
      check("rd_en_while_empty", int'(s_rd_en && s_empty), 0);
      if (s_valid && s_ready && !s_flush) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          exp_w = sb.pop_front();
          check("m_data", s_data, exp_w);
          check("m_last", s_last, int'(beat_m == PKT_LEN - 1));
          check("pkt_cnt", s_pkt, pkt_m);
          if (beat_m == PKT_LEN - 1) begin
            beat_m = 0;
            pkt_m  = pkt_m + 16'd1;
          end else begin
            beat_m = beat_m + 1;
          end
        end
      end
      if (stall_prev) begin
        check("hold_valid", s_valid, 1);
        check("hold_data", s_data, held.data);
        check("hold_last", s_last, held.last);
      end
      stall_prev = s_valid && !s_ready && !s_flush;
      held.data  = s_data;
      held.last  = s_last;
      if (s_flush) begin
        drop_n = sb.size() - fifo_q.size();
        for (int i = 0; i < drop_n; i++) void'(sb.pop_front());
        beat_m     = 0;
        stall_prev = 1'b0;
      end
      if (s_rd_en && fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
      if (s_wr_en && fifo_q.size() < FIFO_DEPTH) begin
        fifo_q.push_back(s_wr_data);
        sb.push_back(s_wr_data);
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 wr_en = 1'b1; wr_data = DW'(base + i);
    end
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || m_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(k < 300), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic find_rd_en();
    c0 = -1;
    for (int k = 0; k < 30 && c0 < 0; k++) begin
      @(negedge clk);
      if (fifo_rd_en) c0 = cyc;
    end
    check("rd_en_seen", int'(c0 >= 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: idle after reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_rd_en", fifo_rd_en, 0);
      check("t1_valid", m_valid, 0);
      check("t1_last", m_last, 0);
      check("t1_pkt_cnt", pkt_cnt, 0);
      check("t1_data", m_data, 0);
    end

    // 2: five words, latency and back-to-back output
    @(posedge clk); #1 m_ready = 1'b1;
    fork
      write_words(5, 0);
      begin
        find_rd_en();
        if (c0 >= 0) begin
          @(negedge clk);
          check("t2_valid_lat1", m_valid, 0);
          @(negedge clk);
          for (int i = 0; i < 5; i++) begin
            check("t2_valid", m_valid, 1);
            check("t2_data", m_data, i);
            @(negedge clk);
          end
          check("t2_valid_end", m_valid, 0);
        end
      end
    join
    wait_drain("t2_drain");

    // 3: framing from a fresh reset
    do_reset();
    fork
      write_words(8, 'h10);
      begin
        nbeat = 0;
        mask  = '0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (m_valid && m_ready) begin
            if (m_last) mask[nbeat] = 1'b1;
            nbeat++;
          end
        end
      end
    join
    check("t3_beats", nbeat, 8);
    check("t3_last_mask", mask, 'h88);
    check("t3_pkt_cnt", pkt_cnt, 2);

    // 4: stall with full buffer, then full-rate drain
    @(posedge clk); #1 m_ready = 1'b0;
    write_words(16, 'h20);
    repeat (10) @(negedge clk);
    check("t4_fifo_count", fifo_q.size(), 12);
    check("t4_rd_en", fifo_rd_en, 0);
    check("t4_valid", m_valid, 1);
    check("t4_head", m_data, 'h20);
    @(posedge clk); #1 m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t4_stream_valid", m_valid, 1);
      check("t4_stream_data", m_data, 'h20 + i);
    end
    wait_drain("t4_drain");

    // 5: flush with three buffered and one in flight, mid-packet
    write_words(2, 'h40);
    wait_drain("t5_pre_drain");
    @(posedge clk); #1 m_ready = 1'b0;
    fork
      write_words(10, 'h50);
      begin
        find_rd_en();
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("t5_rd_en_in_flush", fifo_rd_en, 0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("t5_valid_after_flush", m_valid, 0);
      end
    join
    @(posedge clk); #1 m_ready = 1'b1;
    nbeat = 0;
    mask  = '0;
    for (int k = 0; k < 60 && nbeat < 6; k++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        check("t5_data", m_data, 'h54 + nbeat);
        if (m_last) mask[nbeat] = 1'b1;
        nbeat++;
      end
    end
    check("t5_beats", nbeat, 6);
    check("t5_last_mask", mask, 'h08);
    wait_drain("t5_drain");

    // 6: random traffic with a reset in the middle
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      wr_en   = ($urandom % 100) < 60;
      wr_data = DW'($urandom);
      m_ready = ($urandom % 100) < 60;
      if (i == 150) rst_n = 1'b0;
      if (i == 152) rst_n = 1'b1;
    end
    @(posedge clk); #1 wr_en = 1'b0; m_ready = 1'b1;
    wait_drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
